// File: rtl/h14tx_rst_seq_pkg.sv
// Shared types for the TX reset sequencer: FSM state encoding and the
// helper that sizes the shared hold/guard/stagger counter.
package h14tx_rst_pkg;

    typedef enum logic [2:0] {
        Hold      = 3'd0,
        WaitLock  = 3'd1,
        WaitGuard = 3'd2,
        Release   = 3'd3,
        Run       = 3'd4
    } rst_seq_state_t;

    function automatic int cnt_width(input int hold, input int guard, input int stagger);
        int m;
        m = hold;
        if (guard > m) m = guard;
        if (stagger > m) m = stagger;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/h14tx_sync_ff.sv
// Two-flop synchroniser with asynchronous active-high reset to RST_VAL.
module h14tx_sync_ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/h14tx_rst_seq.sv
// Multi-domain reset sequencer: qualifies PLL lock, holds, guards, then releases
// domains in staggered order. Define H14TX_RST_SEQ_LOCK_SYNC_EN to synchronise lock.
module h14tx_rst_seq
    import h14tx_rst_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int GUARD_CYCLES   = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lock,
    input  logic                   ext_rst_n,
    input  logic                   soft_rst,
    input  logic                   clr_status,
    output logic [NUM_DOMAINS-1:0] sync_rst_n,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [CNT_W-1:0]       lock_loss_cnt
);

    localparam int CW = cnt_width(HOLD_CYCLES, GUARD_CYCLES, STAGGER_CYCLES);
    localparam int IW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CW-1:0]    HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0]    STAG_LAST  = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(NUM_DOMAINS - 1);
    localparam logic [CNT_W-1:0] LCNT_MAX   = '1;

    if (NUM_DOMAINS < 1 || HOLD_CYCLES < 1 || GUARD_CYCLES < 1 ||
        STAGGER_CYCLES < 1 || CNT_W < 1) begin : g_param_err
        $error("h14tx_rst_seq: NUM_DOMAINS, *_CYCLES and CNT_W must all be >= 1");
    end

    logic lock_q;

`ifdef H14TX_RST_SEQ_LOCK_SYNC_EN
    h14tx_sync_ff #(.RST_VAL(1'b0)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (lock),
        .q_o (lock_q)
    );
`else
    assign lock_q = lock;
`endif

    rst_seq_state_t       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] mask_q, mask_d;
    logic                 ready_q, ready_d;
    logic                 lost_q, lost_d;
    logic [CNT_W-1:0]     lcnt_q, lcnt_d;
    logic                 req;
    logic                 lock_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= Hold;
            cnt_q   <= '0;
            idx_q   <= '0;
            mask_q  <= '0;
            ready_q <= 1'b0;
            lost_q  <= 1'b0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
            lcnt_q  <= lcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        ready_d  = ready_q;
        lost_d   = lost_q;
        lcnt_d   = lcnt_q;
        req      = !ext_rst_n || soft_rst;
        lock_evt = (state_q == Release || state_q == Run) && !lock_q;

        // A lock event on the same cycle as clr_status counts from zero.
        if (clr_status) begin
            lost_d = 1'b0;
            lcnt_d = '0;
        end
        if (lock_evt) begin
            lost_d = 1'b1;
            if (lcnt_d != LCNT_MAX) lcnt_d = lcnt_d + 1'b1;
        end

        unique case (state_q)
            Hold: begin
                if (req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = WaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WaitLock: begin
                cnt_d = '0;
                if (req) begin
                    state_d = Hold;
                end else if (lock_q) begin
                    state_d = WaitGuard;
                end
            end
            WaitGuard: begin
                if (req) begin
                    state_d = Hold;
                    cnt_d   = '0;
                end else if (!lock_q) begin
                    state_d = WaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == GUARD_LAST) begin
                    state_d = Release;
                    cnt_d   = '0;
                    idx_d   = '0;
                    mask_d  = NUM_DOMAINS'(1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            Release, Run: begin
                // All domains drop together; release is the only staggered direction.
                if (req || !lock_q) begin
                    state_d = Hold;
                    cnt_d   = '0;
                    idx_d   = '0;
                    mask_d  = '0;
                    ready_d = 1'b0;
                end else if (state_q == Release) begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = Run;
                            ready_d = 1'b1;
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            mask_d = (mask_q << 1) | NUM_DOMAINS'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = Hold;
                cnt_d   = '0;
                idx_d   = '0;
                mask_d  = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign sync_rst_n    = mask_q;
    assign ready         = ready_q;
    assign lock_lost     = lost_q;
    assign lock_loss_cnt = lcnt_q;

endmodule
